// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue/writeback controller: op codes,
// instruction field positions and FSM state encoding.
package alu_issue_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_NOT   = 4'b0110;
    localparam logic [3:0] OP_MAX   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_LT    = 4'b1010;
    localparam logic [3:0] OP_EQ    = 4'b1011;
    localparam logic [3:0] OP_LOADI = 4'b1100;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    localparam int OP_HI       = 31;
    localparam int OP_LO       = 28;
    localparam int RD_HI       = 27;
    localparam int RD_LO       = 24;
    localparam int RS1_HI      = 23;
    localparam int RS1_LO      = 20;
    localparam int RS2_HI      = 19;
    localparam int RS2_LO      = 16;
    localparam int IMM_SEL_BIT = 15;
    localparam int IMM16_HI    = 15;
    localparam int IMM15_HI    = 14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    // Ops that actually drive the ALU (arithmetic/logic plus compares).
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_EQ);
    endfunction

    // Ops that produce a register writeback.
    function automatic logic is_write_op(input logic [3:0] op);
        return (op <= OP_SRL) || (op == OP_LOADI);
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 16x32 register file: two operand read ports, one debug read port and one
// write port. R0 always reads as zero and ignores writes.
module alu_issue_regfile
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  ra1,
    output logic [31:0] rd1,
    input  logic [3:0]  ra2,
    output logic [31:0] rd2,
    input  logic [3:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    logic [31:0] regs_q [16];
    logic [31:0] regs_d [16];

    // Next-state of the array: single write port, R0 never written.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != 4'd0)) begin
            regs_d[waddr] = wdata;
        end
    end

    // Register storage, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1      = (ra1 == 4'd0)      ? 32'd0 : regs_q[ra1];
    assign rd2      = (ra2 == 4'd0)      ? 32'd0 : regs_q[ra2];
    assign dbg_data = (dbg_addr == 4'd0) ? 32'd0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the combinational filter ALU.
// One instruction per four cycles: IDLE -> DECODE -> EXEC -> WB.
// Build option: define ALU_ISSUE_IMM_EN to let ALU ops take a 15-bit
// zero-extended immediate as operand Y when instr[15] is set.
module alu_issue_ctrl
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [3:0]  alu_code,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    input  logic [31:0] alu_z,
    input  logic        alu_cmp,
    output logic        wb_valid,
    output logic [3:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        cmp_flag,
    input  logic [3:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    state_e      state_q,    state_d;
    logic [31:0] instr_q,    instr_d;
    logic [3:0]  alu_code_q, alu_code_d;
    logic [31:0] alu_x_q,    alu_x_d;
    logic [31:0] alu_y_q,    alu_y_d;
    logic        wb_valid_q, wb_valid_d;
    logic [3:0]  wb_addr_q,  wb_addr_d;
    logic [31:0] wb_data_q,  wb_data_d;
    logic        cmp_flag_q, cmp_flag_d;

    logic [3:0]  op, rd, rs1, rs2;
    logic [31:0] rs1_data, rs2_data, y_sel;

    assign op  = instr_q[OP_HI:OP_LO];
    assign rd  = instr_q[RD_HI:RD_LO];
    assign rs1 = instr_q[RS1_HI:RS1_LO];
    assign rs2 = instr_q[RS2_HI:RS2_LO];

`ifdef ALU_ISSUE_IMM_EN
    assign y_sel = instr_q[IMM_SEL_BIT] ? {17'b0, instr_q[IMM15_HI:0]} : rs2_data;
`else
    assign y_sel = rs2_data;
`endif

    // Register file writes only while the WB pulse is out, so dbg_data shows
    // the old value during WB and the new one after that edge.
    alu_issue_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_valid_q && (state_q == ST_WB)),
        .waddr    (wb_addr_q),
        .wdata    (wb_data_q),
        .ra1      (rs1),
        .rd1      (rs1_data),
        .ra2      (rs2),
        .rd2      (rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Next-state and datapath loads for each FSM phase.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        alu_code_d = alu_code_q;
        alu_x_d    = alu_x_q;
        alu_y_d    = alu_y_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        cmp_flag_d = cmp_flag_q;
        unique case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // LOADI/NOP park the ALU on OP_NOP and leave X/Y untouched.
                if (is_alu_op(op)) begin
                    alu_code_d = op;
                    alu_x_d    = rs1_data;
                    alu_y_d    = y_sel;
                end else begin
                    alu_code_d = OP_NOP;
                end
                state_d = ST_DECODE == ST_DECODE ? ST_EXEC : ST_EXEC;
            end
            ST_EXEC: begin
                // Capture the settled ALU result at the end of EXEC.
                if (is_write_op(op)) begin
                    wb_valid_d = 1'b1;
                    wb_addr_d  = rd;
                    wb_data_d  = (op == OP_LOADI) ? {16'b0, instr_q[IMM16_HI:0]} : alu_z;
                end
                if ((op == OP_LT) || (op == OP_EQ)) begin
                    cmp_flag_d = alu_cmp;
                end
                state_d = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and datapath state; reset aborts any in-flight instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            alu_code_q <= OP_NOP;
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            cmp_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            alu_code_q <= alu_code_d;
            alu_x_q    <= alu_x_d;
            alu_y_q    <= alu_y_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            cmp_flag_q <= cmp_flag_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE) && !rst;
    assign alu_code    = alu_code_q;
    assign alu_x       = alu_x_q;
    assign alu_y       = alu_y_q;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign cmp_flag    = cmp_flag_q;

endmodule
